mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 16, giving the width of the word address driven to the data RAM.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a load/store request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = word.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores.
REQ-014 The block SHALL have port rsp_split, output, 1 bit: the access spanned two words.
REQ-015 The block SHALL have port mem_a, output, ADDR_BITS bits: data RAM word address.
REQ-016 The block SHALL have port mem_we, output, 4 bits: data RAM byte-lane write enables; lane k = bits 8k+7:8k.
REQ-017 The block SHALL have port mem_d, output, 32 bits: data RAM write data.
REQ-018 The block SHALL have port mem_spo, input, 32 bits: data RAM combinational read data for mem_a.

Function
REQ-019 The block SHALL implement states IDLE, BEAT0, BEAT1 and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, a handshake (req_valid=1, req_ready=1) SHALL register all request fields and move to BEAT0.
REQ-021 The block SHALL define o = addr[1:0] and n = 1, 2 or 4 bytes from size; the access is split iff o+n > 4.
REQ-022 In BEAT0, mem_a SHALL equal addr[ADDR_BITS+1:2], and mem_we SHALL set lanes o..min(3, o+n-1) for stores.
REQ-023 In BEAT1, mem_a SHALL equal the BEAT0 address +1, wrapping modulo 2^ADDR_BITS, and mem_we SHALL set lanes 0..o+n-5 for stores.
REQ-024 In BEAT0 and BEAT1, mem_d SHALL equal req_wdata rotated left by 8*o bits.
REQ-025 BEAT0 SHALL capture mem_spo as w0; BEAT1 SHALL capture mem_spo as w1.
REQ-026 BEAT0 SHALL go to BEAT1 if the access is split, else to RESP; BEAT1 SHALL always go to RESP.
REQ-027 Load data SHALL be the low n bytes of {w1,w0} >> 8*o, sign- or zero-extended to 32 bits per req_unsigned.
REQ-028 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_split SHALL be held stable until rsp_ready=1.
REQ-029 After the RESP handshake, the block SHALL return to IDLE on the next cycle.
REQ-030 Latency from the accepting edge to rsp_valid SHALL be 2 cycles when not split and 3 cycles when split.
REQ-031 mem_we SHALL be 4'b0 in IDLE and RESP, in every load beat, and in any cycle with rst_n=0.
REQ-032 mem_a and mem_d SHALL be 0 in IDLE and RESP.
REQ-033 A request presented while req_ready=0 SHALL be ignored and SHALL NOT be captured.

Reset
REQ-034 On a clock edge with rst_n=0, the state SHALL become IDLE, and the following outputs SHALL be 0: rsp_valid, rsp_rdata, rsp_split, mem_a, mem_d and mem_we.
REQ-035 Reset asserted mid-operation (BEAT0, BEAT1 or RESP) SHALL abandon the access without a response, with no write after the reset edge.
REQ-036 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Verification
REQ-037 Aligned word load: addr 0x100 with mem word 0x40 = 0x8899AABB -> rsp_rdata 0x8899AABB, rsp_split 0, rsp_valid 2 cycles after accept.
REQ-038 Signed byte load: addr 0x103 over word 0x80112233 -> rsp_rdata 0xFFFFFF80; the same access with req_unsigned=1 -> 0x00000080.
REQ-039 Split word store: addr 0x0FE, wdata 0xDDCCBBAA -> BEAT0 at mem_a 0x3F with mem_we 1100 and mem_d 0xBBAADDCC; BEAT1 at mem_a 0x40 with mem_we 0011; response after 3 cycles with rsp_split 1.
REQ-040 Address wrap: half load at addr 0x3FFFF (ADDR_BITS=16) -> beats at mem_a 0xFFFF then 0x0000.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_rdata stable, req_ready 0, a second req_valid is not accepted until the cycle after the handshake.
REQ-042 Reset during BEAT0 of a split store -> no write in BEAT1, no response, and req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store engine in front of a 32-bit word
// RAM with combinational read. Misaligned accesses that cross a word boundary
// are carried out as two beats; load data is realigned and extended.
module mem_access_unit #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_split,
  output logic [ADDR_BITS-1:0] mem_a,
  output logic [3:0]           mem_we,
  output logic [31:0]          mem_d,
  input  logic [31:0]          mem_spo
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_next;

  logic                 we_q;
  logic                 uns_q;
  logic [1:0]           size_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          w0;
  logic [31:0]          w1;

  logic [1:0]           offset;
  logic [3:0]           size_mask;
  logic [7:0]           lane_span;
  logic                 split;
  logic [ADDR_BITS-1:0] word0;
  logic [31:0]          wdata_rot;
  logic [31:0]          lo_word;
  logic [31:0]          hi_word;
  logic [31:0]          shifted;
  logic [31:0]          load_data;

  // Address bits above the RAM window never reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

  // Decode the captured request: byte lanes across both words, rotated store
  // data, and the realigned/extended load value from the two read words.
  always_comb begin
    offset = addr_q[1:0];
    word0  = addr_q[ADDR_BITS+1:2];
    case (size_q)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_span = {4'b0000, size_mask} << offset;
    split     = |lane_span[7:4];
    wdata_rot = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, offset, 3'b000}));
    lo_word   = (state == BEAT0) ? mem_spo : w0;
    hi_word   = (state == BEAT1) ? mem_spo : w1;
    shifted   = 32'({hi_word, lo_word} >> {offset, 3'b000});
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: one beat for contained accesses, two for word-crossing ones.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BEAT0;
      BEAT0:   state_next = split ? BEAT1 : RESP;
      BEAT1:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; RAM strobes are also gated by reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_a     = '0;
    mem_we    = 4'b0000;
    mem_d     = 32'b0;
    case (state)
      IDLE:  req_ready = rst_n;
      BEAT0: begin
        mem_a  = word0;
        mem_we = we_q ? lane_span[3:0] : 4'b0000;
        mem_d  = wdata_rot;
      end
      BEAT1: begin
        mem_a  = word0 + ADDR_BITS'(1);
        mem_we = we_q ? lane_span[7:4] : 4'b0000;
        mem_d  = wdata_rot;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
    if (!rst_n) mem_we = 4'b0000;
  end

  // Request capture, read-word capture and the held response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= 32'b0;
      w0        <= 32'b0;
      w1        <= 32'b0;
      rsp_rdata <= 32'b0;
      rsp_split <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr[ADDR_BITS+1:0];
          wdata_q <= req_wdata;
        end
        BEAT0: begin
          w0 <= mem_spo;
          if (!split) begin
            rsp_rdata <= we_q ? 32'b0 : load_data;
            rsp_split <= 1'b0;
          end
        end
        BEAT1: begin
          w1        <= mem_spo;
          rsp_rdata <= we_q ? 32'b0 : load_data;
          rsp_split <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_rdata <= 32'b0;
          rsp_split <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
